// File: rtl/btn_debounce_pkg.sv
// Shared types and timing constants for the pushbutton debouncer.
// Channel FSM encoding plus the counter-width helper used by the top and each channel.
package btn_debounce_pkg;

  typedef enum logic [1:0] {
    LO     = 2'd0,
    ARM_HI = 2'd1,
    HI     = 2'd2,
    ARM_LO = 2'd3
  } db_state_t;

  localparam int unsigned DB_10MS_100MHZ = 32'd1000000;
  localparam int unsigned HOLD_1S_100MHZ = 32'd100000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A CNT_W-bit counter must reach max(DEBOUNCE, HOLD) - 1.
  function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned hold);
    return $clog2(max_u(deb, hold));
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debouncer channel: two-flop synchronizer, four-state qualify FSM and a
// shared debounce/hold counter producing a clean level and a one-shot long-hold pulse.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DB_10MS_100MHZ,
  parameter int unsigned HOLD_CYCLES     = HOLD_1S_100MHZ,
  parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic btn_db_o,
  output logic hold_pulse_o
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);

  logic             sync0_q;
  logic             sync1_q;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             hold_q, hold_d;
  logic             fired_q, fired_d;

  // Synchronizer chain; only sync1_q is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= btn_raw_i;
      sync1_q <= sync0_q;
    end
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LO;
      cnt_q   <= CNT_ZERO;
      db_q    <= 1'b0;
      hold_q  <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      fired_q <= fired_d;
    end
  end

  // Next-state logic: ARM_* counters exit at their terminal value, HI counter saturates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    hold_d  = 1'b0;
    fired_d = fired_q;
    case (state_q)
      LO: begin
        fired_d = 1'b0;
        if (sync1_q) begin
          state_d = ARM_HI;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = LO;
        end
      end
      ARM_HI: begin
        if (!sync1_q) begin
          state_d = LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = HI;
          db_d    = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      HI: begin
        if (!sync1_q) begin
          state_d = ARM_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == HOLD_LAST) begin
          // Saturated: the pulse register fires once, the fired flag blocks repeats.
          cnt_d = cnt_q;
          if (!fired_q) begin
            hold_d  = 1'b1;
            fired_d = 1'b1;
          end else begin
            hold_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ARM_LO: begin
        if (sync1_q) begin
          state_d = HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == DB_LAST) begin
          state_d = LO;
          db_d    = 1'b0;
          cnt_d   = CNT_ZERO;
          fired_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = CNT_ZERO;
        db_d    = 1'b0;
        fired_d = 1'b0;
      end
    endcase
  end

  assign btn_db_o     = db_q;
  assign hold_pulse_o = hold_q;

endmodule

// File: rtl/btn_debounce.sv
// Multi-button debouncer: N_BTN independent channels, each giving a stable
// level for the downstream pulse filter and a one-shot long-hold flag.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DB_10MS_100MHZ,
  parameter int unsigned HOLD_CYCLES     = HOLD_1S_100MHZ
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] hold_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw_i    (btn_raw[g]),
      .btn_db_o     (btn_db[g]),
      .hold_pulse_o (hold_pulse[g])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a run-length/window reference model queues
// expected outputs per clock edge and a negedge monitor compares them.
module tb_btn_debounce;

  localparam int N    = 5;
  localparam int DEB  = 4;
  localparam int HOLD = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] btn_raw = '0;
  logic [N-1:0] btn_db;
  logic [N-1:0] hold_pulse;

  always #5 clk = ~clk;

  btn_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .btn_db     (btn_db),
    .hold_pulse (hold_pulse)
  );

  typedef struct packed {
    logic [N-1:0] db;
    logic [N-1:0] hp;
  } exp_t;

  typedef struct {
    logic [N-1:0] s;
    logic [N-1:0] db;
  } hist_t;

  exp_t  exp_q[$];
  hist_t hist[$];
  logic [N-1:0] raw_pipe[$];
  int           run_len[N];
  logic [N-1:0] m_db;
  logic [N-1:0] m_fired;
  logic [N-1:0] m_s;
  logic [N-1:0] m_hp;
  bit           m_ok;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_pipe.delete();
    raw_pipe.push_back('0);
    raw_pipe.push_back('0);
    hist.delete();
    for (int c = 0; c < N; c++) run_len[c] = 0;
    m_db    = '0;
    m_fired = '0;
  endtask

  // Reference model: the FSM sees raw input two edges late; a level flips after DEB+1
  // consecutive opposite samples; hold fires when HOLD+1 consecutive high samples start
  // at an edge where the debounced level was already high, once per press.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back('{db: '0, hp: '0});
      end else begin
        m_s = raw_pipe.pop_front();
        raw_pipe.push_back(btn_raw);
        for (int c = 0; c < N; c++) begin
          if (m_s[c] != m_db[c]) begin
            run_len[c]++;
            if (run_len[c] == DEB + 1) begin
              m_db[c]    = m_s[c];
              run_len[c] = 0;
              if (!m_s[c]) m_fired[c] = 1'b0;
            end
          end else begin
            run_len[c] = 0;
          end
        end
        hist.push_back('{s: m_s, db: m_db});
        if (hist.size() > HOLD + 1) void'(hist.pop_front());
        m_hp = '0;
        if (hist.size() == HOLD + 1) begin
          for (int c = 0; c < N; c++) begin
            m_ok = hist[0].db[c];
            for (int k = 0; k <= HOLD; k++) if (!hist[k].s[c]) m_ok = 1'b0;
            if (m_ok && !m_fired[c]) begin
              m_hp[c]    = 1'b1;
              m_fired[c] = 1'b1;
            end
          end
        end
        exp_q.push_back('{db: m_db, hp: m_hp});
      end
    end
  end

  // Monitor: outputs are registered, so compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("btn_db", btn_db, e.db);
        check("hold_pulse", hold_pulse, e.hp);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input int cyc);
    btn_raw = v;
    step(cyc);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_btn_db", btn_db, '0);
    check("rst_hold_pulse", hold_pulse, '0);
    step(3);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    step(4);
    rst_n = 1'b1;
    drive(5'b00000, 5);
    // clean press on bit 0
    drive(5'b00001, 12);
    // bounce on bit 1, then stable high
    drive(5'b00011, 2);
    drive(5'b00001, 2);
    drive(5'b00011, 2);
    drive(5'b00001, 12);
    drive(5'b00011, 12);
    // long hold on bit 2, then release
    drive(5'b00111, 40);
    drive(5'b00011, 12);
    // bit 3: hold fires, short release glitch, return
    drive(5'b01011, 30);
    drive(5'b00011, 2);
    drive(5'b01011, 30);
    drive(5'b00011, 12);
    // simultaneous presses
    drive(5'b00000, 12);
    drive(5'b10101, 12);
    drive(5'b00000, 12);
    // reset while qualifying, then while holding
    drive(5'b11111, 4);
    pulse_reset();
    step(12);
    pulse_reset();
    step(30);
    drive(5'b00000, 12);
    // randomized bouncing and holds
    v = '0;
    for (int i = 0; i < 150; i++) begin
      v = v ^ N'($urandom_range(0, 31) & $urandom_range(0, 31));
      drive(v, $urandom_range(1, 25));
    end
    drive(5'b00000, 12);
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
